// File: rtl/vga_timing_if.sv
// ----------------------------------------------------------------------------
// vga_timing_if
//   Bundle of raster timing signals produced by vga_timing_gen and consumed by
//   the colour/pixel stage.
//
//   Signals:
//     hsync      horizontal sync, at level SYNC_ACTIVE during the pulse
//     vsync      vertical sync, at level SYNC_ACTIVE during the pulse
//     blank_n    1 = current pixel lies in the active area
//     row        active-area line index (0 outside the active area)
//     column     active-area pixel index (0 outside the active area)
//     frame_tick one-pixel pulse at the first line of vertical blanking
//     pix_en     pixel enable
//
//   Handshake: pix_en is the only qualifier and behaves as a valid with no
//   ready. A new pixel (row/column/blank_n/sync/frame_tick) is presented after
//   every clk edge at which pix_en was 1 and is held until the next such edge.
//   The raster can never be stalled by the sink, so there is no back-pressure.
//
//   Modports:
//     master  driven by the timing generator
//     slave   observed by the colour stage
// ----------------------------------------------------------------------------
interface vga_timing_if;
  logic       hsync;
  logic       vsync;
  logic       blank_n;
  logic [8:0] row;
  logic [9:0] column;
  logic       frame_tick;
  logic       pix_en;

  modport master (
    output hsync,
    output vsync,
    output blank_n,
    output row,
    output column,
    output frame_tick,
    output pix_en
  );

  modport slave (
    input hsync,
    input vsync,
    input blank_n,
    input row,
    input column,
    input frame_tick,
    input pix_en
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing source for the Tetris display path. Generates active-area
//   coordinates, blank_n, hsync/vsync and a once-per-frame game tick.
//   Default geometry is 640x480@60 Hz on an 800x525 raster.
//
//   Ports:
//     clk   system clock (pixel clock, or 2x pixel clock with PIXEL_DIV2_EN)
//     rst   asynchronous active-low reset
//     vga   vga_timing_if.master: hsync, vsync, blank_n, row, column,
//           frame_tick, pix_en
//
//   Optional build macro PIXEL_DIV2_EN:
//     defined   - clk is twice the pixel rate; an internal toggle flop makes
//                 pix_en high on every second clk (first one on the 2nd clk
//                 after reset release).
//     undefined - pix_en is tied high and clk is the pixel clock.
//
//   Timing model: h_cnt/v_cnt hold the position of the pixel that will be
//   emitted at the next pix_en edge. On that edge the decoded position is
//   registered onto the outputs while the counters step on, so row, column
//   and blank_n always describe the pixel on the wire with no skew between
//   them. hsync/vsync get SYNC_DELAY (0..3) further pixel stages so they can
//   line up with downstream RGB registering.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int SYNC_DELAY  = 1
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_C    = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_C    = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  // Sync idle level, used for reset fill of the delay pipes.
  localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

  // --------------------------------------------------------------------------
  // Pixel enable
  // --------------------------------------------------------------------------
  logic pix_en;

`ifdef PIXEL_DIV2_EN
  logic pix_tgl;

  // Resets to 0, so the first clk after release only arms the toggle and the
  // first pixel edge is the second clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_tgl <= 1'b0;
    end else begin
      pix_tgl <= ~pix_tgl;
    end
  end

  assign pix_en = pix_tgl;
`else
  assign pix_en = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Raster counters and position decode
  // --------------------------------------------------------------------------
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       h_last;
  logic       v_last;
  logic       h_act;
  logic       v_act;
  logic       active_d;
  logic [9:0] column_d;
  logic [8:0] row_d;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       tick_d;

  always_comb begin
    h_last    = 1'b0;
    v_last    = 1'b0;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    h_act     = 1'b0;
    v_act     = 1'b0;
    active_d  = 1'b0;
    column_d  = '0;
    row_d     = '0;
    hsync_raw = SYNC_IDLE;
    vsync_raw = SYNC_IDLE;
    tick_d    = 1'b0;

    // Next position: both counters wrap on the same edge at the raster end.
    h_last = (h_cnt == H_LAST);
    v_last = (v_cnt == V_LAST);
    if (h_last) begin
      h_nxt = '0;
      v_nxt = v_last ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_nxt = h_cnt + 10'd1;
    end

    // Decode of the position about to be emitted.
    h_act    = (h_cnt < H_ACT_C);
    v_act    = (v_cnt < V_ACT_C);
    active_d = h_act && v_act;
    column_d = h_act ? h_cnt : 10'd0;
    // row tracks the line independently of horizontal blanking.
    row_d    = v_act ? v_cnt[8:0] : 9'd0;

    if ((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END)) begin
      hsync_raw = SYNC_ACTIVE;
    end
    // vsync covers whole lines, so it depends on v_cnt only.
    if ((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END)) begin
      vsync_raw = SYNC_ACTIVE;
    end

    tick_d = (h_cnt == 10'd0) && (v_cnt == V_ACT_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Registered pixel outputs
  // --------------------------------------------------------------------------
  logic       blank_n_q;
  logic [9:0] column_q;
  logic [8:0] row_q;
  logic       frame_tick_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_n_q    <= 1'b0;
      column_q     <= '0;
      row_q        <= '0;
      frame_tick_q <= 1'b0;
    end else if (pix_en) begin
      blank_n_q    <= active_d;
      column_q     <= column_d;
      row_q        <= row_d;
      frame_tick_q <= tick_d;
    end else begin
      // Holding edge: keep the pixel but never let the tick span two clks.
      frame_tick_q <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Sync delay pipes
  //   Stage 0 is aligned with blank_n; stage SYNC_DELAY drives the port.
  // --------------------------------------------------------------------------
  logic [SYNC_DELAY:0] hs_pipe;
  logic [SYNC_DELAY:0] vs_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_pipe <= {(SYNC_DELAY + 1){SYNC_IDLE}};
      vs_pipe <= {(SYNC_DELAY + 1){SYNC_IDLE}};
    end else if (pix_en) begin
      hs_pipe[0] <= hsync_raw;
      vs_pipe[0] <= vsync_raw;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Interface drive
  // --------------------------------------------------------------------------
  assign vga.hsync      = hs_pipe[SYNC_DELAY];
  assign vga.vsync      = vs_pipe[SYNC_DELAY];
  assign vga.blank_n    = blank_n_q;
  assign vga.row        = row_q;
  assign vga.column     = column_q;
  assign vga.frame_tick = frame_tick_q;
  assign vga.pix_en     = pix_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Three full-size instances differ only
//   in SYNC_DELAY (0, 1, 2); a fourth uses a tiny 16x12 raster so frame-level
//   behaviour (vsync, frame_tick spacing, raster wrap) fits a short run.
//
//   Small raster: H = 8 active, 2 fp, 3 sync, 3 bp (16 total)
//                 V = 6 active, 2 fp, 2 sync, 2 bp (12 total), 192 px/frame.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_timing_if if_d0 ();
  vga_timing_if if_d1 ();
  vga_timing_if if_d2 ();
  vga_timing_if if_sm ();

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (.clk(clk), .rst(rst), .vga(if_d0));
  vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (.clk(clk), .rst(rst), .vga(if_d1));
  vga_timing_gen #(.SYNC_DELAY(2)) u_d2 (.clk(clk), .rst(rst), .vga(if_d2));
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_DELAY(0)
  ) u_sm (.clk(clk), .rst(rst), .vga(if_sm));

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk: drive/sample happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until one pix_en edge has been consumed (bounded).
  task automatic pix_step();
    logic pe;
    bit   done;
    done = 1'b0;
    for (int k = 0; k < 4 && !done; k++) begin
      pe = if_d0.pix_en;
      tick();
      if (pe === 1'b1) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_fail++;
      $error("FAIL pix_en_timeout: observed no pix_en in 4 clk expected pix_en");
    end
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Line capture
  int b_cnt, b_first, b2_cnt, hs0_cnt, hs0_first, hs1_first, hs2_first, hs2_cnt, vs0_low;
  logic [9:0] col_last, col_blank;
  // Frame capture (small raster)
  logic [9:0] s_col [0:399];
  logic [8:0] s_row [0:399];
  logic       s_bl  [0:399];
  int t_cnt, t_first, t_second, vs_cnt, vs_first, hs_cnt, hs_first, bl_cnt;

  initial begin
    // ---------------- reset -------------------------------------------------
    rst = 1'b0;
    repeat (5) tick();
    check("rst_row",     if_d0.row, 0);
    check("rst_col",     if_d0.column, 0);
    check("rst_blank",   if_d0.blank_n, 0);
    check("rst_tick",    if_d0.frame_tick, 0);
    check("rst_hs_d0",   if_d0.hsync, 1);
    check("rst_vs_d0",   if_d0.vsync, 1);
    check("rst_hs_d2",   if_d2.hsync, 1);
    check("rst_vs_d2",   if_d2.vsync, 1);
    check("rst_blank_sm", if_sm.blank_n, 0);

    rst = 1'b1;
`ifdef PIXEL_DIV2_EN
    check("pix_en_first", if_d0.pix_en, 0);
`else
    check("pix_en_first", if_d0.pix_en, 1);
`endif
    pix_step();
    check("first_row",   if_d0.row, 0);
    check("first_col",   if_d0.column, 0);
    check("first_blank", if_d0.blank_n, 1);
    check("first_hs",    if_d0.hsync, 1);
    check("first_vs",    if_d0.vsync, 1);

    // ---------------- one line on the full-size instances ------------------
    b_cnt = 0; b_first = -1; b2_cnt = 0; hs0_cnt = 0; hs0_first = -1;
    hs1_first = -1; hs2_first = -1; hs2_cnt = 0; vs0_low = 0;
    col_last = '0; col_blank = '1;
    for (int p = 0; p < 800; p++) begin
      if (if_d0.blank_n) b_cnt++;
      else if (b_first < 0) b_first = p;
      if (if_d2.blank_n) b2_cnt++;
      if (!if_d0.hsync) begin
        hs0_cnt++;
        if (hs0_first < 0) hs0_first = p;
      end
      if (!if_d1.hsync && hs1_first < 0) hs1_first = p;
      if (!if_d2.hsync) begin
        hs2_cnt++;
        if (hs2_first < 0) hs2_first = p;
      end
      if (!if_d0.vsync) vs0_low++;
      if (p == 639) col_last = if_d0.column;
      if (p == 700) col_blank = if_d0.column;
      pix_step();
    end
    check("line_blank_cnt",  b_cnt, 640);
    check("line_blank_end",  b_first, 640);
    check("line_blank_d2",   b2_cnt, 640);
    check("line_hs_cnt",     hs0_cnt, 96);
    check("line_hs_start",   hs0_first, 656);
    check("line_hs_d1",      hs1_first, 657);
    check("line_hs_d2",      hs2_first, 658);
    check("line_hs_d2_cnt",  hs2_cnt, 96);
    check("line_vs_idle",    vs0_low, 0);
    check("line_col_last",   col_last, 639);
    check("line_col_blank",  col_blank, 0);
    check("line1_row",       if_d0.row, 1);
    check("line1_col",       if_d0.column, 0);
    check("line1_blank",     if_d0.blank_n, 1);

    // ---------------- asynchronous reset mid-line --------------------------
    repeat (100) pix_step();
    check("mid_row", if_d0.row, 1);
    check("mid_col", if_d0.column, 100);
    #2;
    rst = 1'b0;
    #1;
    check("async_row",   if_d0.row, 0);
    check("async_col",   if_d0.column, 0);
    check("async_blank", if_d0.blank_n, 0);
    check("async_hs_d2", if_d2.hsync, 1);
    check("async_bl_sm", if_sm.blank_n, 0);
    @(negedge clk);
    tick();
    tick();
    check("hold_rst_blank", if_d0.blank_n, 0);
    rst = 1'b1;
    pix_step();
    check("rerel_row",   if_d0.row, 0);
    check("rerel_col",   if_d0.column, 0);
    check("rerel_blank", if_d0.blank_n, 1);

    // ---------------- frames on the small raster ---------------------------
    t_cnt = 0; t_first = -1; t_second = -1; vs_cnt = 0; vs_first = -1;
    hs_cnt = 0; hs_first = -1; bl_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      s_col[n] = if_sm.column;
      s_row[n] = if_sm.row;
      s_bl[n]  = if_sm.blank_n;
      if (if_sm.frame_tick) begin
        t_cnt++;
        if (t_first < 0) t_first = n;
        else if (t_second < 0) t_second = n;
      end
      if (n < 192) begin
        if (!if_sm.vsync) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = n;
        end
        if (!if_sm.hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = n;
        end
        if (if_sm.blank_n) bl_cnt++;
      end
      pix_step();
    end
    check("sm_tick_cnt",   t_cnt, 2);
    check("sm_tick_pos",   t_first, 96);
    check("sm_tick_gap",   t_second - t_first, 192);
    check("sm_vs_cnt",     vs_cnt, 32);
    check("sm_vs_start",   vs_first, 128);
    check("sm_hs_cnt",     hs_cnt, 36);
    check("sm_hs_start",   hs_first, 10);
    check("sm_blank_cnt",  bl_cnt, 48);
    check("sm_last_act_row", s_row[87], 5);
    check("sm_last_act_col", s_col[87], 7);
    check("sm_last_act_bl",  s_bl[87], 1);
    check("sm_hblank_row",   s_row[88], 5);
    check("sm_hblank_col",   s_col[88], 0);
    check("sm_hblank_bl",    s_bl[88], 0);
    check("sm_tick_row",     s_row[96], 0);
    check("sm_end_bl",       s_bl[191], 0);
    check("sm_wrap_row",     s_row[192], 0);
    check("sm_wrap_col",     s_col[192], 0);
    check("sm_wrap_bl",      s_bl[192], 1);
    check("sm_wrap_col1",    s_col[193], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the Tetris display path; sits directly upstream of the colour/pixel stage.
- Produces the active-area pixel coordinates (row, column), the blank_n qualifier, the hsync/vsync pulses and a once-per-frame game tick.
- Default timing is 640x480@60 Hz with a 25 MHz pixel clock (800x525 total raster).
- All outputs are registered. The colour stage consumes row/column/blank_n combinationally; hsync/vsync can be delayed to match downstream RGB registering.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
SYNC_DELAY, 1, extra pixel-enable cycles of delay on hsync/vsync only (0..3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
hsync  out  1  horizontal sync, level SYNC_ACTIVE during pulse
vsync  out  1  vertical sync, level SYNC_ACTIVE during pulse
blank_n  out  1  1 = current pixel in active area
row  out  9  active-area line index 0..V_ACTIVE-1, 0 outside active
column  out  10  active-area pixel index 0..H_ACTIVE-1, 0 outside active
frame_tick  out  1  one-pixel-enable pulse at start of vertical blanking
pix_en  out  1  pixel enable; counters advance only when 1

Behaviour:
- Reset: rst is the only reset. It is asynchronous and active-low: rst=0 takes effect immediately, and release is sampled on clk.
- Values while rst=0: h_cnt=0, v_cnt=0, row=0, column=0, blank_n=0, frame_tick=0, hsync=vsync=!SYNC_ACTIVE, delay pipe filled with !SYNC_ACTIVE.
- Counters: internal h_cnt and v_cnt are 10 bits. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525).
- On each clk with pix_en=1, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps to 0 at V_TOTAL-1 when h_cnt also wraps. Both wrap in the same cycle.
- Output registration: outputs are registered from the next-state counters, so row/column/blank_n describe the pixel being emitted that cycle. Latency from counter to output is 0 pixel cycles. No skew between row, column and blank_n.
- blank_n = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- column = h_cnt when h_cnt < H_ACTIVE, else 0. row = v_cnt[8:0] when v_cnt < V_ACTIVE, else 0.
- Sync windows:
  - Raw hsync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - Raw vsync is active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), whole lines.
  - Both pass through a SYNC_DELAY-stage shift register that advances on pix_en.
  - SYNC_DELAY=0 means sync is aligned with blank_n.
- frame_tick is 1 for exactly one pix_en cycle, when h_cnt=0 and v_cnt=V_ACTIVE (first blank line). Game logic uses it as a 60 Hz gravity/input tick.
- Hold on pix_en=0: when pix_en=0, all outputs hold their previous values and frame_tick is forced 0.
- Reset mid-frame: every output takes its reset value within the same cycle, asynchronously. The first pixel after release is (0,0) with blank_n=1 on the first pix_en cycle.

Optional Feature:
Macro: PIXEL_DIV2_EN
- Defined: clk is 50 MHz. An internal toggle flop (reset 0) generates pix_en = 1 every second clk, first pix_en on the 2nd clk after reset release. Counters, sync pipe and outputs advance only on pix_en; outputs hold for 2 clk per pixel.
- Not defined: pix_en is tied to 1 and clk is the 25 MHz pixel clock.

Test Plan:
- Reset 0 for 5 clk, then release -> first cycle row=0, column=0, blank_n=1; hsync=vsync=1 (SYNC_ACTIVE=0).
- Run one line -> blank_n=1 for 640 pix_en cycles, then 0 for 160. With SYNC_DELAY=0, hsync=0 for exactly 96 cycles starting at column-cycle 656. Line length is 800.
- Run one full frame -> vsync low for exactly 2 lines (1600 cycles) starting at line 490. frame_tick fires once at line 480 pixel 0. Total 420000 cycles between ticks.
- Check wrap at h_cnt=799, v_cnt=524 -> next cycle row=0, column=0, blank_n=1, both counters wrap together.
- SYNC_DELAY=2 -> hsync falling edge occurs 2 pixels after the SYNC_DELAY=0 position; blank_n unchanged.
- Assert rst at line 300 pixel 100 -> outputs reset immediately without a clock edge. PIXEL_DIV2_EN build: pix_en toggles 0,1,0,1 and row/column change every 2 clk.
